// File: rtl/dms_pkg.sv
// Shared types and constants for the DMS transmitter.
// Optional feature macro: DMS_TX_PARITY_EN adds the PAR state (parity symbol per frame).
package dms_pkg;

    localparam int SYM_LEN_DEF       = 8;
    localparam int KEY_W_DEF         = 32;
    localparam int SYM_HI_ZERO       = 2;
    localparam int SYM_HI_ONE_OFFSET = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG_N    = 3'd1,
        CFG_D    = 3'd2,
        CFG_CAPS = 3'd3,
        WAIT     = 3'd4,
        SYM      = 3'd5,
`ifdef DMS_TX_PARITY_EN
        PAR      = 3'd6,
`endif
        END      = 3'd7
    } state_t;

    // floor(log2(v)); the largest key exponent that still fits the key register
    function automatic int flog2(input int v);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= v) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/dms_sym_gen.sv
// Symbol generator: one SYM_LEN-cycle pulse-width symbol per start, long high for 1, short for 0.
module dms_sym_gen
    import dms_pkg::*;
#(
    parameter int SYM_LEN = SYM_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_in,
    output logic str,
    output logic done,
    output logic active
);

    localparam int CW = $clog2(SYM_LEN);
    localparam logic [CW-1:0] LAST    = CW'(SYM_LEN - 1);
    localparam logic [CW-1:0] HI_ONE  = CW'(SYM_LEN - SYM_HI_ONE_OFFSET);
    localparam logic [CW-1:0] HI_ZERO = CW'(SYM_HI_ZERO);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;
    logic          active_q, active_d;

    // a start in the last cycle restarts the counter so symbols abut
    always_comb begin
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = '0;
            bit_d    = bit_in;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            active_q <= active_d;
        end
    end

    assign str    = active_q && (cnt_q < (bit_q ? HI_ONE : HI_ZERO));
    assign done   = active_q && (cnt_q == LAST);
    assign active = active_q;

endmodule

// File: rtl/dms_tx.sv
// DMS transmitter: serialises the key configuration, then pulse-width encodes message bits.
// Optional feature macro: DMS_TX_PARITY_EN appends an even-parity symbol to every frame.
module dms_tx
    import dms_pkg::*;
#(
    parameter int SYM_LEN = SYM_LEN_DEF,
    parameter int KEY_W   = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [3:0]       cfg_n,
    input  logic [KEY_W-1:0] cfg_d,
    input  logic [KEY_W-1:0] cfg_caps,
    input  logic             msg_valid,
    input  logic             msg_bit,
    input  logic             msg_last,
    output logic             msg_ready,
    output logic             str,
    output logic             mode,
    output logic             configured,
    output logic             busy,
    output logic             cfg_err,
    output logic             underrun
);

    localparam int MAX_N = flog2(KEY_W);
    // the counter must also reach 3 to walk the 4-bit n field
    localparam int CW = (MAX_N < 2) ? 2 : MAX_N;
    localparam logic [3:0]       MAX_N4 = 4'(MAX_N);
    localparam logic [KEY_W-1:0] ONE    = KEY_W'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic [KEY_W-1:0] d_q, d_d;
    logic [KEY_W-1:0] caps_q, caps_d;
    logic             last_q, last_d;
    logic             configured_q, configured_d;
    logic             cfg_err_q, cfg_err_d;
    logic             underrun_q, underrun_d;
`ifdef DMS_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             sym_start, sym_bit, sym_str, sym_done, sym_active;
    logic [CW-1:0]    key_last, key_idx;
    logic [1:0]       n_idx;
    logic             n_bit, d_bit, caps_bit;

    dms_sym_gen #(
        .SYM_LEN (SYM_LEN)
    ) u_sym (
        .clk    (clk),
        .reset  (reset),
        .start  (sym_start),
        .bit_in (sym_bit),
        .str    (sym_str),
        .done   (sym_done),
        .active (sym_active)
    );

    // keys go out MSB first, so the bit index counts down from 2^n-1
    always_comb begin
        key_last = CW'((32'd1 << n_q) - 32'd1);
        key_idx  = key_last - cnt_q;
        n_idx    = 2'd3 - cnt_q[1:0];
        n_bit    = n_q[n_idx];
        d_bit    = |(d_q & (ONE << key_idx));
        caps_bit = |(caps_q & (ONE << key_idx));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        d_d          = d_q;
        caps_d       = caps_q;
        last_d       = last_q;
        configured_d = configured_q;
        cfg_err_d    = 1'b0;
        underrun_d   = 1'b0;
        msg_ready    = 1'b0;
        sym_start    = 1'b0;
        sym_bit      = msg_bit;
`ifdef DMS_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE, WAIT: begin
                if (cfg_start) begin
                    if (cfg_n > MAX_N4) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        n_d          = cfg_n;
                        d_d          = cfg_d;
                        caps_d       = cfg_caps;
                        cnt_d        = '0;
                        configured_d = 1'b0;
                        state_d      = CFG_N;
                    end
                end else if (state_q == WAIT && configured_q) begin
                    msg_ready = 1'b1;
                    if (msg_valid) begin
                        sym_start = 1'b1;
                        last_d    = msg_last;
`ifdef DMS_TX_PARITY_EN
                        par_d     = msg_bit;
`endif
                        state_d   = SYM;
                    end
                end
            end
            CFG_N: begin
                if (cnt_q == CW'(3)) begin
                    cnt_d   = '0;
                    state_d = CFG_D;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CFG_D: begin
                if (cnt_q == key_last) begin
                    cnt_d   = '0;
                    state_d = CFG_CAPS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CFG_CAPS: begin
                if (cnt_q == key_last) begin
                    cnt_d        = '0;
                    configured_d = 1'b1;
                    state_d      = WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SYM: begin
                // mid-frame: take the next bit in a symbol's last cycle, or any cycle while starved
                if (!last_q) begin
                    if (sym_done || !sym_active) begin
                        msg_ready = 1'b1;
                        if (msg_valid) begin
                            sym_start = 1'b1;
                            last_d    = msg_last;
`ifdef DMS_TX_PARITY_EN
                            par_d     = par_q ^ msg_bit;
`endif
                        end else if (sym_done) begin
                            underrun_d = 1'b1;
                        end
                    end
                end else if (sym_done) begin
`ifdef DMS_TX_PARITY_EN
                    sym_start = 1'b1;
                    sym_bit   = par_q;
                    state_d   = PAR;
`else
                    state_d   = END;
`endif
                end
            end
`ifdef DMS_TX_PARITY_EN
            PAR: begin
                if (sym_done) state_d = END;
            end
`endif
            END: begin
                state_d = WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            d_q          <= '0;
            caps_q       <= '0;
            last_q       <= 1'b0;
            configured_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef DMS_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            d_q          <= d_d;
            caps_q       <= caps_d;
            last_q       <= last_d;
            configured_q <= configured_d;
            cfg_err_q    <= cfg_err_d;
            underrun_q   <= underrun_d;
`ifdef DMS_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    always_comb begin
        str = 1'b0;
        case (state_q)
            CFG_N:    str = n_bit;
            CFG_D:    str = d_bit;
            CFG_CAPS: str = caps_bit;
            SYM:      str = sym_str;
`ifdef DMS_TX_PARITY_EN
            PAR:      str = sym_str;
`endif
            END:      str = 1'b1;
            default:  str = 1'b0;
        endcase
    end

    assign mode       = (state_q == CFG_N) || (state_q == CFG_D) || (state_q == CFG_CAPS);
    assign busy       = (state_q != IDLE) && (state_q != WAIT);
    assign configured = configured_q;
    assign cfg_err    = cfg_err_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dms_tx.sv
// Bench for dms_tx: expected line activity is built per transaction from the protocol rules
// and compared every cycle; literal waveforms pin the key scenarios.
module tb_dms_tx;

    localparam int SYM_LEN = 8;
    localparam int KEY_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_start;
    logic [3:0]       cfg_n;
    logic [KEY_W-1:0] cfg_d;
    logic [KEY_W-1:0] cfg_caps;
    logic             msg_valid, msg_bit, msg_last;
    logic             msg_ready, str, mode, configured, busy, cfg_err, underrun;

    typedef struct packed {
        logic s;
        logic m;
        logic r;
        logic c;
        logic b;
        logic e;
        logic u;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        obs_now, obs_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] str_hist  = '0;
    logic [63:0] mode_hist = '0;
    logic [63:0] rdy_hist  = '0;
    logic [63:0] und_hist  = '0;

    dms_tx #(
        .SYM_LEN (SYM_LEN),
        .KEY_W   (KEY_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_n      (cfg_n),
        .cfg_d      (cfg_d),
        .cfg_caps   (cfg_caps),
        .msg_valid  (msg_valid),
        .msg_bit    (msg_bit),
        .msg_last   (msg_last),
        .msg_ready  (msg_ready),
        .str        (str),
        .mode       (mode),
        .configured (configured),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic obs_t mk(input logic s, input logic m, input logic r, input logic c,
                                input logic b, input logic e, input logic u);
        return {s, m, r, c, b, e, u};
    endfunction

    // compare process: one sample 1 time unit after every rising edge
    always begin
        @(posedge clk);
        #1;
        cyc++;
        obs_now   = {str, mode, msg_ready, configured, busy, cfg_err, underrun};
        str_hist  = {str_hist[62:0], str};
        mode_hist = {mode_hist[62:0], mode};
        rdy_hist  = {rdy_hist[62:0], msg_ready};
        und_hist  = {und_hist[62:0], underrun};
        if (exp_q.size() > 0) begin
            obs_exp = exp_q.pop_front();
            n_checks++;
            if (obs_now !== obs_exp) begin
                n_fail++;
                $display("FAIL cycle %0d: got str/mode/ready/cfgd/busy/err/und=%b, required %b",
                         cyc, obs_now, obs_exp);
            end
        end else begin
            check("quiet_line", 64'({str, mode, cfg_err, underrun}), 64'(0));
        end
    end

    // ---------------- behavioural model ----------------
    task automatic model_config(input logic [3:0] n, input logic [31:0] d, input logic [31:0] caps);
        for (int i = 3; i >= 0; i--)
            exp_q.push_back(mk(n[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = (1 << n) - 1; i >= 0; i--)
            exp_q.push_back(mk(d[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = (1 << n) - 1; i >= 0; i--)
            exp_q.push_back(mk(caps[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic model_symbol(input logic b, input logic ready_end);
        int hi;
        hi = b ? SYM_LEN - 2 : 2;
        for (int c = 0; c < SYM_LEN; c++)
            exp_q.push_back(mk(c < hi, 1'b0, (c == SYM_LEN - 1) && ready_end, 1'b1, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic model_tail();
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic model_frame(input logic [7:0] bits, input int len);
        logic par;
        par = 1'b0;
        for (int i = 0; i < len; i++) begin
            par = par ^ bits[i];
            model_symbol(bits[i], i != len - 1);
        end
`ifdef DMS_TX_PARITY_EN
        model_symbol(par, 1'b0);
`endif
        model_tail();
    endtask

    // ---------------- stimulus helpers (entered and left on a falling edge) ----------------
    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_config(input logic [3:0] n, input logic [31:0] d, input logic [31:0] caps);
        cfg_n     = n;
        cfg_d     = d;
        cfg_caps  = caps;
        cfg_start = 1'b1;
        model_config(n, d, caps);
        @(negedge clk);
        cfg_start = 1'b0;
        drain("config");
        $display("config n=%0d d=%h caps=%h done at cycle %0d", n, d, caps, cyc);
    endtask

    task automatic send_frame(input logic [7:0] bits, input int len, input logic poke);
        model_frame(bits, len);
        for (int i = 0; i < len; i++) begin
            msg_valid = 1'b1;
            msg_bit   = bits[i];
            msg_last  = (i == len - 1);
            if (poke && i == 1) begin
                cfg_start = 1'b1;
                cfg_n     = 4'd1;
            end
            repeat (i == 0 ? 1 : SYM_LEN) @(posedge clk);
            @(negedge clk);
            cfg_start = 1'b0;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_bit   = 1'b0;
        drain("frame");
        $display("frame bits=%b len=%0d done at cycle %0d", bits, len, cyc);
    endtask

    task automatic underrun_frame();
        localparam int GAP = 3;
        model_symbol(1'b1, 1'b1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        for (int g = 1; g < GAP; g++)
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        model_symbol(1'b0, 1'b0);
        model_tail();
        msg_valid = 1'b1;
        msg_bit   = 1'b1;
        msg_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (SYM_LEN - 1 + GAP) @(posedge clk);
        @(negedge clk);
        msg_valid = 1'b1;
        msg_bit   = 1'b0;
        msg_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        drain("underrun");
        $display("underrun frame done at cycle %0d", cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_n     = '0;
        cfg_d     = '0;
        cfg_caps  = '0;
        msg_valid = 1'b0;
        msg_bit   = 1'b0;
        msg_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({str, mode, msg_ready, configured, busy, cfg_err, underrun}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        $display("reset released at cycle %0d", cyc);

        // illegal exponent from IDLE
        cfg_n     = 4'd9;
        cfg_start = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        cfg_start = 1'b0;
        drain("illegal_n");
        check("illegal_n_still_idle", 64'({busy, mode, configured}), 64'(0));
        $display("illegal cfg_n=9 rejected at cycle %0d", cyc);

        // n=2, d=1010, caps=0001
        do_config(4'd2, 32'hA, 32'h1);
        check("cfg_str_literal", 64'(str_hist[12:0]), 64'(13'b0010101000010));
        check("cfg_mode_literal", 64'(mode_hist[12:0]), 64'(13'b1111111111110));
        check("configured_after", 64'(configured), 64'(1));

        // frame 1,0,1 with a stray cfg_start inside a symbol
        send_frame(8'b0000_0101, 3, 1'b1);
        check("frame101_str", 64'(str_hist[25:0]), 64'(26'b11111100_11000000_11111100_10));
        check("frame101_ready", 64'(rdy_hist[25:0]), 64'(26'b00000001_00000001_00000000_01));

        // frame 1,1,0
        send_frame(8'b0000_0011, 3, 1'b0);
`ifdef DMS_TX_PARITY_EN
        check("frame110_par_str", str_hist[33:0], 64'(34'b11111100_11111100_11000000_11000000_10));
`else
        check("frame110_str", 64'(str_hist[25:0]), 64'(26'b11111100_11111100_11000000_10));
`endif

        underrun_frame();
        check("underrun_pulse", 64'(und_hist[20:0]), 64'(21'b00000000_100_00000000_00));

        // reset during the sixth CFG_D cycle of an n=3 configuration
        do_reset();
        cfg_n     = 4'd3;
        cfg_d     = 32'hA5;
        cfg_caps  = 32'h3C;
        cfg_start = 1'b1;
        model_config(4'd3, 32'hA5, 32'h3C);
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_reset_mode", 64'(mode), 64'(1));
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_mid_cfg", 64'({str, mode, configured}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) exp_q.push_back('0);
        drain("post_reset_quiet");
        $display("reset during CFG_D handled at cycle %0d", cyc);

        // widest legal key, then narrowest
        do_config(4'd5, 32'h8000_0001, 32'hFFFF_0000);
        do_reset();
        @(negedge clk);
        do_config(4'd0, 32'h1, 32'h0);
        check("cfg_n0_str", 64'(str_hist[6:0]), 64'(7'b0000100));
        check("cfg_n0_mode", 64'(mode_hist[6:0]), 64'(7'b1111110));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dms_tx.md
DMS_TX -- requirements
Module: dms_tx

Interface
REQ-001 The block SHALL have the parameter SYM_LEN, default 8, meaning cycles per message symbol; legal range 6..32.
REQ-002 The block SHALL have the parameter KEY_W, default 32, meaning key register width; the largest legal n is log2(KEY_W).
REQ-003 clk  in  1  the single clock; every sequential element SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_start  in  1  one-cycle request to transmit the configuration.
REQ-006 cfg_n  in  4  key exponent n; key length is 2^n bits.
REQ-007 cfg_d  in  KEY_W  key d; bit 2^n-1 is the first bit sent.
REQ-008 cfg_caps  in  KEY_W  mask capsN, with the same ordering as cfg_d.
REQ-009 msg_valid, msg_bit, msg_last  in  1 each  plaintext bit stream; msg_last marks the final bit of a frame.
REQ-010 msg_ready  out  1  the block accepts a bit on a cycle where msg_valid and msg_ready are both high.
REQ-011 str  out  1  serial line to the downstream decryption receiver.
REQ-012 mode  out  1  high while configuration bits are on str.
REQ-013 configured, busy  out  1 each  status outputs.
REQ-014 cfg_err, underrun  out  1 each  one-cycle error pulses.

Function
REQ-015 The state machine SHALL have exactly these states: IDLE, CFG_N, CFG_D, CFG_CAPS, WAIT, SYM, PAR, END.
REQ-016 In IDLE, when cfg_start is high and cfg_n is greater than log2(KEY_W), the block SHALL pulse cfg_err, latch nothing, and stay in IDLE.
REQ-017 In IDLE, when cfg_start is high and cfg_n is legal, the block SHALL latch cfg_n, cfg_d and cfg_caps, and go to CFG_N on the next cycle.
REQ-018 In CFG_N, the block SHALL drive mode=1 and drive str with n[3], n[2], n[1], n[0], one bit per cycle.
REQ-019 In CFG_D, the block SHALL drive mode=1 and drive str with d[2^n-1] down to d[0].
REQ-020 In CFG_CAPS, the block SHALL drive mode=1 and drive str with capsN[2^n-1] down to capsN[0].
REQ-021 mode SHALL be high for exactly 4+2*2^n consecutive cycles, and str SHALL be aligned to mode in the same cycles.
REQ-022 When CFG_CAPS completes, the block SHALL set configured=1 and go to WAIT.
REQ-023 In WAIT, the block SHALL drive mode=0 and str=0, and SHALL drive msg_ready=1 only while configured=1.
REQ-024 Each accepted bit b SHALL produce a symbol of exactly SYM_LEN cycles: str high for H cycles, then low for SYM_LEN-H cycles.
REQ-025 For b=1, H SHALL equal SYM_LEN-2; for b=0, H SHALL equal 2.
REQ-026 The first symbol SHALL start on the cycle after the handshake.
REQ-027 msg_ready SHALL also be high in the last cycle of a SYM symbol whose bit did not carry msg_last, so that the next symbol starts back-to-back.
REQ-028 If msg_valid is low in the last cycle of a mid-frame symbol, the block SHALL pulse underrun once and hold str=0 until a bit is accepted.
REQ-029 After the symbol of the msg_last bit, the block SHALL enter PAR if DMS_TX_PARITY_EN is defined, else END.
REQ-030 In END, the block SHALL drive str=1 for one cycle, then str=0, and return to WAIT; this edge closes the last symbol at the receiver.
REQ-031 busy SHALL be 1 in every state except IDLE and WAIT.
REQ-032 cfg_start in WAIT SHALL start reconfiguration; cfg_start in any other state SHALL be ignored.
REQ-033 When cfg_start and msg_valid are both high in WAIT, configuration SHALL win and msg_ready SHALL be 0 that cycle.

Reset
REQ-034 While reset is high, the block SHALL force str=0, mode=0, msg_ready=0, configured=0, busy=0, cfg_err=0 and underrun=0, clear all counters and latched keys, and enter IDLE.
REQ-035 A reset mid-configuration or mid-symbol SHALL abort the transfer with no further bits emitted.

Configuration
REQ-036 When DMS_TX_PARITY_EN is defined, PAR SHALL emit one extra symbol carrying the even parity (XOR) of all frame bits, then go to END.
REQ-037 When DMS_TX_PARITY_EN is undefined, the PAR state and the parity register SHALL be absent.

Structure
REQ-038 The package dms_pkg SHALL hold the state enum, the SYM_LEN default, the KEY_W default, and the high-cycle constants SYM_HI_ZERO=2 and SYM_HI_ONE_OFFSET=2.
REQ-039 One sub-module, dms_sym_gen, SHALL contain the symbol cycle counter and the str waveform for a given bit, with start and done ports.

Verification
REQ-040 The bench SHALL check: reset, then cfg_n=2, d=4'b1010, caps=4'b0001 -> mode high for 12 cycles; str=0,0,1,0,1,0,1,0,0,0,0,1; configured=1 afterwards.
REQ-041 The bench SHALL check: cfg_n=9 -> cfg_err pulse, mode stays 0, state remains IDLE.
REQ-042 The bench SHALL check: frame 1,0,1 with msg_last on the third bit, SYM_LEN=8 -> str = 11111100 11000000 11111100 then 1,0; msg_ready high in symbol last cycles only.
REQ-043 The bench SHALL check: msg_valid dropped after the first bit of the frame -> one underrun pulse, str held 0, and resumption on the next valid.
REQ-044 The bench SHALL check: reset asserted in cycle 6 of CFG_D -> str=0, mode=0 and configured=0 immediately; no bits emitted after release until a new cfg_start.
REQ-045 The bench SHALL check, with DMS_TX_PARITY_EN defined: frame 1,1,0 -> a parity-0 symbol (11000000) before the END pulse.
